histogram_stats: RTL and testbench

- Downstream consumer of the histogram readout stream. It captures one frame of bin counts (ready-qualified, one bin per cycle, bin 0 first) and computes summary statistics: peak bin, peak count, total events, occupied-bin count and first/last occupied bin.
- Results are registered and flagged with a one-cycle ready pulse.
- Results are held until the next frame completes; the consuming control logic reads them there.

---
 rtl/histogram_stats_if.sv | 34 +++
 rtl/histogram_stats.sv | 171 +++++++++++++++++
 tb/tb_histogram_stats.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/histogram_stats_if.sv
`default_nettype none
// ============================================================================
// histogram_stats_if : histogram readout stream in, frame statistics out. Rev 1.0
// ============================================================================
interface histogram_stats_if #(
  parameter int BIN_WIDTH   = 7,
  parameter int COUNT_WIDTH = 16
);
  logic                             histogramValueReady;
  logic [COUNT_WIDTH-1:0]           histogramValue;
  logic                             statsReady;
  logic [BIN_WIDTH-1:0]             peakBin;
  logic [COUNT_WIDTH-1:0]           peakCount;
  logic [COUNT_WIDTH+BIN_WIDTH-1:0] totalCount;
  logic [BIN_WIDTH:0]               occupiedBins;
  logic [BIN_WIDTH-1:0]             firstBin;
  logic [BIN_WIDTH-1:0]             lastBin;
  logic                             anyOccupied;
  logic                             lengthError;
  logic [COUNT_WIDTH+2*BIN_WIDTH-1:0] weightedSum;

  modport master (
    output histogramValueReady, histogramValue,
    input  statsReady, peakBin, peakCount, totalCount, occupiedBins,
           firstBin, lastBin, anyOccupied, lengthError, weightedSum
  );

  modport slave (
    input  histogramValueReady, histogramValue,
    output statsReady, peakBin, peakCount, totalCount, occupiedBins,
           firstBin, lastBin, anyOccupied, lengthError, weightedSum
  );
endinterface
`default_nettype wire

// File: rtl/histogram_stats.sv
`default_nettype none
// ============================================================================
// histogram_stats : per-frame peak/total/occupancy statistics of a histogram
// readout. Optional index*count accumulation: HISTSTATS_WEIGHTED_SUM_EN. Rev 1.0
// ============================================================================
module histogram_stats #(
  parameter int BIN_WIDTH   = 7,
  parameter int COUNT_WIDTH = 16,
  parameter int NUM_BINS    = 1 << BIN_WIDTH
) (
  input  wire logic        clk,
  input  wire logic        reset,
  histogram_stats_if.slave bus
);
  localparam int TW = COUNT_WIDTH + BIN_WIDTH;
  localparam int WW = COUNT_WIDTH + 2 * BIN_WIDTH;
  localparam logic [BIN_WIDTH:0] c_num_bins = (BIN_WIDTH+1)'(NUM_BINS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 state_q;
  logic [BIN_WIDTH:0]     beat_q, beat_d;
  logic                   over_q, over_d;
  logic [BIN_WIDTH-1:0]   peak_bin_q, peak_bin_d;
  logic [COUNT_WIDTH-1:0] peak_cnt_q, peak_cnt_d;
  logic [TW-1:0]          total_q, total_d;
  logic [BIN_WIDTH:0]     occ_q, occ_d;
  logic [BIN_WIDTH-1:0]   first_q, first_d;
  logic [BIN_WIDTH-1:0]   last_q, last_d;
  logic                   any_q, any_d;

  logic                   stats_ready_out_q;
  logic [BIN_WIDTH-1:0]   peak_bin_out_q;
  logic [COUNT_WIDTH-1:0] peak_cnt_out_q;
  logic [TW-1:0]          total_out_q;
  logic [BIN_WIDTH:0]     occ_out_q;
  logic [BIN_WIDTH-1:0]   first_out_q;
  logic [BIN_WIDTH-1:0]   last_out_q;
  logic                   any_out_q;
  logic                   len_err_out_q;

  logic                   w_keep;
  logic [BIN_WIDTH-1:0]   w_idx;
  logic                   w_nz;

`ifdef HISTSTATS_WEIGHTED_SUM_EN
  logic [WW-1:0] wsum_q, wsum_d, wsum_out_q;
`endif

  // Accumulators restart from zero whenever a beat is not a COLLECT
  // continuation, so a beat in IDLE or DONE naturally becomes bin 0.
  always_comb begin
    w_keep     = (state_q == COLLECT);
    beat_d     = w_keep ? beat_q     : '0;
    over_d     = w_keep ? over_q     : 1'b0;
    peak_bin_d = w_keep ? peak_bin_q : '0;
    peak_cnt_d = w_keep ? peak_cnt_q : '0;
    total_d    = w_keep ? total_q    : '0;
    occ_d      = w_keep ? occ_q      : '0;
    first_d    = w_keep ? first_q    : '0;
    last_d     = w_keep ? last_q     : '0;
    any_d      = w_keep ? any_q      : 1'b0;
`ifdef HISTSTATS_WEIGHTED_SUM_EN
    wsum_d     = w_keep ? wsum_q     : '0;
`endif
    w_idx = beat_d[BIN_WIDTH-1:0];
    w_nz  = |bus.histogramValue;
    if (bus.histogramValueReady) begin
      if (beat_d != c_num_bins) begin
        total_d = total_d + TW'(bus.histogramValue);
        if (bus.histogramValue > peak_cnt_d) begin
          peak_cnt_d = bus.histogramValue;
          peak_bin_d = w_idx;
        end
        if (w_nz) begin
          if (!any_d) first_d = w_idx;
          occ_d  = occ_d + (BIN_WIDTH+1)'(1);
          last_d = w_idx;
          any_d  = 1'b1;
        end
`ifdef HISTSTATS_WEIGHTED_SUM_EN
        wsum_d = wsum_d + WW'(w_idx) * WW'(bus.histogramValue);
`endif
        beat_d = beat_d + (BIN_WIDTH+1)'(1);
      end else begin
        over_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= IDLE;
      beat_q            <= '0;
      over_q            <= 1'b0;
      peak_bin_q        <= '0;
      peak_cnt_q        <= '0;
      total_q           <= '0;
      occ_q             <= '0;
      first_q           <= '0;
      last_q            <= '0;
      any_q             <= 1'b0;
      stats_ready_out_q <= 1'b0;
      peak_bin_out_q    <= '0;
      peak_cnt_out_q    <= '0;
      total_out_q       <= '0;
      occ_out_q         <= '0;
      first_out_q       <= '0;
      last_out_q        <= '0;
      any_out_q         <= 1'b0;
      len_err_out_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_q <= bus.histogramValueReady ? COLLECT : IDLE;
        COLLECT: state_q <= bus.histogramValueReady ? COLLECT : DONE;
        DONE:    state_q <= bus.histogramValueReady ? COLLECT : IDLE;
        default: state_q <= IDLE;
      endcase
      beat_q            <= beat_d;
      over_q            <= over_d;
      peak_bin_q        <= peak_bin_d;
      peak_cnt_q        <= peak_cnt_d;
      total_q           <= total_d;
      occ_q             <= occ_d;
      first_q           <= first_d;
      last_q            <= last_d;
      any_q             <= any_d;
      stats_ready_out_q <= (state_q == DONE);
      if (state_q == DONE) begin
        peak_bin_out_q <= peak_bin_q;
        peak_cnt_out_q <= peak_cnt_q;
        total_out_q    <= total_q;
        occ_out_q      <= occ_q;
        first_out_q    <= first_q;
        last_out_q     <= last_q;
        any_out_q      <= any_q;
        len_err_out_q  <= over_q || (beat_q != c_num_bins);
      end
    end
  end

`ifdef HISTSTATS_WEIGHTED_SUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wsum_q     <= '0;
      wsum_out_q <= '0;
    end else begin
      wsum_q <= wsum_d;
      if (state_q == DONE) wsum_out_q <= wsum_q;
    end
  end
  assign bus.weightedSum = wsum_out_q;
`else
  assign bus.weightedSum = '0;
`endif

  assign bus.statsReady   = stats_ready_out_q;
  assign bus.peakBin      = peak_bin_out_q;
  assign bus.peakCount    = peak_cnt_out_q;
  assign bus.totalCount   = total_out_q;
  assign bus.occupiedBins = occ_out_q;
  assign bus.firstBin     = first_out_q;
  assign bus.lastBin      = last_out_q;
  assign bus.anyOccupied  = any_out_q;
  assign bus.lengthError  = len_err_out_q;
endmodule
`default_nettype wire

// File: tb/tb_histogram_stats.sv
`default_nettype none
// ============================================================================
// tb_histogram_stats : frame table + scoreboard bench for histogram_stats. Rev 1.0
// ============================================================================
module tb_histogram_stats;
  localparam int BW = 7;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  histogram_stats_if #(.BIN_WIDTH(BW), .COUNT_WIDTH(CW)) hif ();

  histogram_stats #(.BIN_WIDTH(BW), .COUNT_WIDTH(CW), .NUM_BINS(1 << BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  typedef struct {
    int     kind;
    int     len;
    int     gap;
    longint peak_bin, peak_cnt, total, occ, first, last, any, lerr, wsum;
  } vec_t;

  typedef struct {
    vec_t v;
    int   cyc;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];

  function automatic logic [CW-1:0] gen(int kind, int i);
    case (kind)
      1: return (i == 10) ? 16'd5 : ((i == 40 || i == 90) ? 16'd9 : 16'd0);
      2: return 16'hFFFF;
      3: return 16'd1;
      4: return CW'(i);
      5: return (i == 0) ? 16'd3 : ((i == 127) ? 16'd2 : 16'd0);
      default: return 16'd0;
    endcase
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_statsReady"}, longint'(hif.statsReady), 0);
    chk({tag, "_peakBin"},    longint'(hif.peakBin), 0);
    chk({tag, "_peakCount"},  longint'(hif.peakCount), 0);
    chk({tag, "_totalCount"}, longint'(hif.totalCount), 0);
    chk({tag, "_occupied"},   longint'(hif.occupiedBins), 0);
    chk({tag, "_firstBin"},   longint'(hif.firstBin), 0);
    chk({tag, "_lastBin"},    longint'(hif.lastBin), 0);
    chk({tag, "_any"},        longint'(hif.anyOccupied), 0);
    chk({tag, "_lengthErr"},  longint'(hif.lengthError), 0);
    chk({tag, "_weighted"},   longint'(hif.weightedSum), 0);
  endtask

  // Inputs change #1 after a rising edge; the beat is sampled by the next edge.
  task automatic drive_frame(vec_t v, bit expect_result);
    exp_t e;
    for (int i = 0; i < v.len; i++) begin
      hif.histogramValueReady = 1'b1;
      hif.histogramValue      = gen(v.kind, i);
      @(posedge clk);
      #1;
    end
    hif.histogramValueReady = 1'b0;
    hif.histogramValue      = '0;
    if (expect_result) begin
      e.v   = v;
      e.cyc = cyc + 2;
      sbq.push_back(e);
    end
    for (int g = 0; g < v.gap; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(string tag);
    for (int t = 0; t < 20 && sbq.size() != 0; t++) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", tag, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic monitor();
    exp_t   e;
    logic   prev_sr = 1'b0;
    longint wexp;
    forever begin
      @(negedge clk);
      if (prev_sr) chk("pulse_width", longint'(hif.statsReady), 0);
      prev_sr = hif.statsReady;
      if (hif.statsReady) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_statsReady: pulse at cycle %0d, expected none", cyc);
        end else begin
          e = sbq.pop_front();
`ifdef HISTSTATS_WEIGHTED_SUM_EN
          wexp = e.v.wsum;
`else
          wexp = 0;
`endif
          chk("latency",      longint'(cyc), longint'(e.cyc));
          chk("peakBin",      longint'(hif.peakBin), e.v.peak_bin);
          chk("peakCount",    longint'(hif.peakCount), e.v.peak_cnt);
          chk("totalCount",   longint'(hif.totalCount), e.v.total);
          chk("occupiedBins", longint'(hif.occupiedBins), e.v.occ);
          chk("firstBin",     longint'(hif.firstBin), e.v.first);
          chk("lastBin",      longint'(hif.lastBin), e.v.last);
          chk("anyOccupied",  longint'(hif.anyOccupied), e.v.any);
          chk("lengthError",  longint'(hif.lengthError), e.v.lerr);
          chk("weightedSum",  longint'(hif.weightedSum), wexp);
        end
      end
    end
  endtask

  initial begin
    //        kind len  gap pbin pcnt   total    occ first last any lerr wsum
    vecs[0] = '{0, 128, 3,   0,    0,       0,    0,  0,    0,  0,  0,         0};
    vecs[1] = '{1, 128, 1,  40,    9,      23,    3, 10,   90,  1,  0,      1220};
    vecs[2] = '{4, 128, 1, 127,  127,    8128,  127,  1,  127,  1,  0,    690880};
    vecs[3] = '{2, 128, 3,   0, 65535, 8388480, 128,  0,  127,  1,  0, 532668480};
    vecs[4] = '{3, 100, 1,   0,    1,     100,  100,  0,   99,  1,  1,      4950};
    vecs[5] = '{3, 130, 4,   0,    1,     128,  128,  0,  127,  1,  1,      8128};
    vecs[6] = '{5, 128, 2,   0,    3,       5,    2,  0,  127,  1,  0,       254};

    reset                   = 1'b0;
    hif.histogramValueReady = 1'b0;
    hif.histogramValue      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    fork
      begin
        for (int k = 0; k < 7; k++) drive_frame(vecs[k], 1'b1);
        wait_drain("table");

        // Abort a ramp frame with reset at beat 60: no result may be reported.
        begin
          vec_t part;
          part     = vecs[2];
          part.len = 60;
          part.gap = 0;
          drive_frame(part, 1'b0);
        end
        hif.histogramValueReady = 1'b1;
        hif.histogramValue      = gen(4, 60);
        reset                   = 1'b0;
        @(posedge clk);
        #1;
        reset                   = 1'b1;
        hif.histogramValueReady = 1'b0;
        hif.histogramValue      = '0;
        repeat (10) @(posedge clk);
        #1;
        chk_zero("midreset");

        drive_frame(vecs[1], 1'b1);
        wait_drain("after_reset");
        repeat (2) @(posedge clk);
      end
      monitor();
    join_any
    disable fork;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
